// File: rtl/pix_window_pkg.sv
// Shared defaults and index helpers for the pixel window buffer.
// Pixel (r,c) lives at a row-major or column-major flat index.
package pix_window_pkg;

  localparam int PIX_W_DEF   = 8;
  localparam int ROW_PIX_DEF = 8;
  localparam int DEPTH_DEF   = 15;
  localparam int WCNT_W_DEF  = 16;

  function automatic int rm_idx(input int r, input int c, input int row_pix);
    return (r * row_pix) + c;
  endfunction

  function automatic int cm_idx(input int r, input int c, input int depth);
    return (c * depth) + r;
  endfunction

  // Width needed to count 0..depth held rows.
  function automatic int fill_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pixel_window_order.sv
// Maps a row-major row array onto the output window in row-major or
// column-major (transposed) order. Purely combinational.
module pixel_window_order
  import pix_window_pkg::*;
#(
  parameter int PIX_W   = PIX_W_DEF,
  parameter int ROW_PIX = ROW_PIX_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic [DEPTH*ROW_PIX*PIX_W-1:0] rows_flat,
  input  logic                           transpose,
  output logic [DEPTH*ROW_PIX*PIX_W-1:0] win_flat
);

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < DEPTH; r++) begin
      for (int c = 0; c < ROW_PIX; c++) begin
        if (transpose)
          win_flat[cm_idx(r, c, DEPTH)*PIX_W +: PIX_W] = rows_flat[rm_idx(r, c, ROW_PIX)*PIX_W +: PIX_W];
        else
          win_flat[rm_idx(r, c, ROW_PIX)*PIX_W +: PIX_W] = rows_flat[rm_idx(r, c, ROW_PIX)*PIX_W +: PIX_W];
      end
    end
  end

endmodule

// File: rtl/pixel_window_buffer.sv
// Holds the last DEPTH input rows and emits a registered DEPTH x ROW_PIX
// window (sliding or block) under valid/ready flow control.
module pixel_window_buffer
  import pix_window_pkg::*;
#(
  parameter int PIX_W   = PIX_W_DEF,
  parameter int ROW_PIX = ROW_PIX_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int WCNT_W  = WCNT_W_DEF
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ROW_PIX*PIX_W-1:0]       in_data,
  input  logic                           slide,
  input  logic                           transpose,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DEPTH*ROW_PIX*PIX_W-1:0] out_data,
  output logic [$clog2(DEPTH+1)-1:0]     fill_level,
  output logic [WCNT_W-1:0]              win_cnt
);

  localparam int ROW_W  = ROW_PIX * PIX_W;
  localparam int WIN_W  = DEPTH * ROW_W;
  localparam int FILL_W = fill_width(DEPTH);

  logic [ROW_W-1:0] row_q [DEPTH];
  logic [WIN_W-1:0] shifted_flat;
  logic [WIN_W-1:0] ordered;
  logic             accept;
  logic             capture;
  logic             handoff;
  logic             fill_full;
  logic             fill_pre;

  assign in_ready  = !reset && !(out_valid && !out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign fill_full = (fill_level == FILL_W'(DEPTH));
  assign fill_pre  = (fill_level == FILL_W'(DEPTH - 1));
  assign capture   = accept && (fill_pre || (fill_full && slide));
  assign handoff   = out_valid && out_ready;

  // Capture sees the array as it will look after this accept's shift.
  always_comb begin
    shifted_flat = '0;
    for (int i = 0; i < DEPTH - 1; i++)
      shifted_flat[i*ROW_W +: ROW_W] = row_q[i+1];
    shifted_flat[(DEPTH-1)*ROW_W +: ROW_W] = in_data;
  end

  pixel_window_order #(
    .PIX_W  (PIX_W),
    .ROW_PIX(ROW_PIX),
    .DEPTH  (DEPTH)
  ) u_order (
    .rows_flat(shifted_flat),
    .transpose(transpose),
    .win_flat (ordered)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        row_q[i] <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      fill_level <= '0;
      win_cnt    <= '0;
    end else if (flush) begin
      fill_level <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < DEPTH - 1; i++)
          row_q[i] <= row_q[i+1];
        row_q[DEPTH-1] <= in_data;
        // A completed block window restarts the fill from empty.
        if (capture && !slide)
          fill_level <= '0;
        else if (!fill_full)
          fill_level <= fill_level + FILL_W'(1);
      end
      if (capture) begin
        out_data  <= ordered;
        out_valid <= 1'b1;
      end else if (handoff) begin
        out_valid <= 1'b0;
      end
      if (handoff)
        win_cnt <= win_cnt + WCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pixel_window_buffer.sv
// Directed bench for pixel_window_buffer: a row-history model predicts every
// output each cycle, and literal checks pin the model to hand-computed values.
module tb_pixel_window_buffer;

  localparam int PIX_W   = 8;
  localparam int ROW_PIX = 8;
  localparam int DEPTH   = 15;
  localparam int WCNT_W  = 16;
  localparam int ROW_W   = ROW_PIX * PIX_W;
  localparam int OW      = DEPTH * ROW_W;
  localparam int FW      = $clog2(DEPTH + 1);

  logic              clock;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [ROW_W-1:0]  in_data;
  logic              slide;
  logic              transpose;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [OW-1:0]     out_data;
  logic [FW-1:0]     fill_level;
  logic [WCNT_W-1:0] win_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  pixel_window_buffer #(
    .PIX_W  (PIX_W),
    .ROW_PIX(ROW_PIX),
    .DEPTH  (DEPTH),
    .WCNT_W (WCNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .slide     (slide),
    .transpose (transpose),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .fill_level(fill_level),
    .win_cnt   (win_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Model: history of the last DEPTH accepted rows, row count, pending window.
  logic [ROW_W-1:0] hist [$];
  logic [OW-1:0]    exp_data;
  int               m_fill;
  logic             m_valid;
  int               m_cnt;
  logic             checking = 1'b0;

  always @(posedge clock) begin
    logic acc, cap, hand;
    logic [ROW_W-1:0] dropped;
    int idx;
    if (reset) begin
      hist.delete();
      for (int i = 0; i < DEPTH; i++) hist.push_back('0);
      m_fill   = 0;
      m_valid  = 1'b0;
      m_cnt    = 0;
      exp_data = '0;
      checking = 1'b1;
    end else if (flush) begin
      m_fill  = 0;
      m_valid = 1'b0;
    end else begin
      hand = m_valid && out_ready;
      acc  = in_valid && !(m_valid && !out_ready);
      cap  = 1'b0;
      if (acc) begin
        hist.push_back(in_data);
        dropped = hist.pop_front();
        cap = (m_fill == DEPTH - 1) || (m_fill == DEPTH && slide);
        if (cap && !slide) m_fill = 0;
        else if (m_fill < DEPTH) m_fill = m_fill + 1;
      end
      if (hand) m_cnt = m_cnt + 1;
      if (cap) begin
        for (int r = 0; r < DEPTH; r++)
          for (int c = 0; c < ROW_PIX; c++) begin
            idx = transpose ? (c * DEPTH + r) : (r * ROW_PIX + c);
            exp_data[idx*PIX_W +: PIX_W] = hist[r][c*PIX_W +: PIX_W];
          end
        m_valid = 1'b1;
      end else if (hand) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Compare process: every output against the model on each falling edge.
  always @(negedge clock) begin
    if (checking) begin
      checkOutput("in_ready", OW'(in_ready), OW'(!reset && !(m_valid && !out_ready)));
      checkOutput("out_valid", OW'(out_valid), OW'(m_valid));
      checkOutput("fill_level", OW'(fill_level), OW'(m_fill));
      checkOutput("win_cnt", OW'(win_cnt), OW'(WCNT_W'(m_cnt)));
      checkOutput("out_data", out_data, exp_data);
    end
  end

  task automatic applyStimulus(input logic v, input logic [ROW_W-1:0] d, input logic sl,
                               input logic tr, input logic fl, input logic ordy, input logic rst);
    in_valid  = v;
    in_data   = d;
    slide     = sl;
    transpose = tr;
    flush     = fl;
    out_ready = ordy;
    reset     = rst;
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  function automatic logic [ROW_W-1:0] flatRow(input logic [7:0] b);
    return {ROW_PIX{b}};
  endfunction

  function automatic logic [ROW_W-1:0] tagRow(input int k);
    logic [ROW_W-1:0] d;
    for (int c = 0; c < ROW_PIX; c++) d[c*PIX_W +: PIX_W] = {4'(k), 4'(c)};
    return d;
  endfunction

  initial begin
    in_valid = 0; in_data = '0; slide = 0; transpose = 0; flush = 0; out_ready = 0; reset = 1;
    applyStimulus(0, '0, 1, 0, 0, 1, 1);
    applyStimulus(0, '0, 1, 0, 0, 1, 1);
    checkOutput("reset_out_valid", OW'(out_valid), OW'(0));
    checkOutput("reset_fill", OW'(fill_level), OW'(0));
    checkOutput("reset_win_cnt", OW'(win_cnt), OW'(0));

    // Sliding fill: row k holds byte k+1.
    for (int k = 0; k < DEPTH; k++) applyStimulus(1, flatRow(8'(k + 1)), 1, 0, 0, 1, 0);
    checkOutput("fill_out_valid", OW'(out_valid), OW'(1));
    checkOutput("fill_byte0", OW'(out_data[7:0]), OW'(8'h01));
    checkOutput("fill_top", OW'(out_data[OW-1 -: 8]), OW'(8'h0F));
    checkOutput("fill_level15", OW'(fill_level), OW'(15));
    checkOutput("model_fill_top", OW'(exp_data[OW-1 -: 8]), OW'(8'h0F));
    applyStimulus(1, flatRow(8'h10), 1, 0, 0, 1, 0);
    checkOutput("slide_byte0", OW'(out_data[7:0]), OW'(8'h02));
    checkOutput("slide_top", OW'(out_data[OW-1 -: 8]), OW'(8'h10));
    applyStimulus(0, '0, 1, 0, 0, 1, 0);
    checkOutput("slide_win_cnt", OW'(win_cnt), OW'(2));

    // Block mode: rows 1..30 give exactly two windows.
    applyStimulus(0, '0, 0, 0, 0, 1, 1);
    for (int k = 1; k <= 30; k++) begin
      applyStimulus(1, flatRow(8'(k)), 0, 0, 0, 1, 0);
      if (k == 15) checkOutput("block_fill_after15", OW'(fill_level), OW'(0));
    end
    checkOutput("block_fill_after30", OW'(fill_level), OW'(0));
    checkOutput("block_byte0", OW'(out_data[7:0]), OW'(8'h10));
    checkOutput("block_top", OW'(out_data[OW-1 -: 8]), OW'(8'h1E));
    checkOutput("model_block_byte0", OW'(exp_data[7:0]), OW'(8'h10));
    applyStimulus(0, '0, 0, 0, 0, 1, 0);
    checkOutput("block_win_cnt", OW'(win_cnt), OW'(2));

    // Transposed window: row r holds {r+1, c}.
    applyStimulus(0, '0, 1, 1, 0, 1, 1);
    for (int k = 1; k <= DEPTH; k++) applyStimulus(1, tagRow(k), 1, 1, 0, 1, 0);
    for (int r = 0; r < DEPTH; r++)
      for (int c = 0; c < ROW_PIX; c++)
        checkOutput("transpose_pix", OW'(out_data[((c*DEPTH)+r)*PIX_W +: PIX_W]), OW'({4'(r + 1), 4'(c)}));

    // Backpressure: consumer stalls for 10 cycles with a row waiting.
    for (int i = 0; i < 10; i++) applyStimulus(1, flatRow(8'hAA), 1, 1, 0, 0, 0);
    checkOutput("bp_in_ready", OW'(in_ready), OW'(0));
    checkOutput("bp_hold_pix", OW'(out_data[((3*DEPTH)+4)*PIX_W +: PIX_W]), OW'(8'h53));
    applyStimulus(1, flatRow(8'hAA), 1, 1, 0, 1, 0);
    checkOutput("bp_resume_cnt", OW'(win_cnt), OW'(1));
    checkOutput("bp_resume_top", OW'(out_data[OW-1 -: 8]), OW'(8'hAA));
    applyStimulus(0, '0, 1, 1, 0, 1, 0);

    // Flush mid-fill.
    applyStimulus(0, '0, 1, 0, 1, 1, 0);
    for (int k = 0; k < 7; k++) applyStimulus(1, flatRow(8'h30 + 8'(k)), 1, 0, 0, 1, 0);
    checkOutput("pre_flush_fill", OW'(fill_level), OW'(7));
    applyStimulus(1, flatRow(8'h77), 1, 0, 1, 1, 0);
    checkOutput("flush_fill", OW'(fill_level), OW'(0));
    checkOutput("flush_out_valid", OW'(out_valid), OW'(0));
    checkOutput("flush_win_cnt", OW'(win_cnt), OW'(2));

    // Reset while a window is pending.
    for (int k = 0; k < DEPTH; k++) applyStimulus(1, flatRow(8'h40 + 8'(k)), 1, 0, 0, 0, 0);
    checkOutput("pend_out_valid", OW'(out_valid), OW'(1));
    applyStimulus(1, flatRow(8'h55), 1, 0, 0, 0, 1);
    checkOutput("rst_out_valid", OW'(out_valid), OW'(0));
    checkOutput("rst_out_data", out_data, '0);
    checkOutput("rst_fill", OW'(fill_level), OW'(0));
    checkOutput("rst_win_cnt", OW'(win_cnt), OW'(0));
    applyStimulus(0, '0, 1, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
